// File: rtl/bcla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// bcla_addsub_pipe
//
// Pipelined WIDTH-bit adder/subtractor built from 4-bit block carry-lookahead
// groups. Each pipeline stage owns 4*GRP_PER_STG result bits. Inside a stage,
// a second-level lookahead forms every group carry directly from the group
// G/P terms and the stage carry-in. The carry between stages is registered.
//
// Result: a + b + c_in   (sub = 0)
//         a - b          (sub = 1, computed as a + ~b + 1; c_in is ignored)
// Latency is NSTG = WIDTH/(4*GRP_PER_STG) cycles and throughput is one beat
// per cycle. An empty stage accepts new data even while downstream is stalled,
// so a stalled pipe buffers up to NSTG beats.
//
// Handshake: a beat moves on a rising edge whenever its valid is high and the
// receiver's ready is high. in_valid/a/b/sub/c_in must be held stable while
// in_valid=1 and in_ready=0. sum/c_out/ovf are stable while out_valid=1 and
// out_ready=0. in_ready may depend combinationally on out_ready.
//
// Optional feature macro: BCLA_OVF_EN
//   defined   -> output ovf (two's-complement overflow, registered with c_out)
//   undefined -> no ovf port and no overflow logic
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand beat valid
//   in_ready   stage 0 can accept a beat
//   a, b       operands (WIDTH bits)
//   sub        1 = a-b, 0 = a+b+c_in
//   c_in       carry-in for addition
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH
//   c_out      carry out of the MSB (for sub: 1 = no borrow)
//   ovf        signed overflow (BCLA_OVF_EN only)
// -----------------------------------------------------------------------------
module bcla_addsub_pipe #(
  parameter int WIDTH       = 32,
  parameter int GRP_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef BCLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW   = 4 * GRP_PER_STG;  // result bits per stage
  localparam int NSTG = WIDTH / SW;       // stages == latency

  // Add one stage slice: 4-bit lookahead groups plus a flattened second-level
  // lookahead (each group carry is a sum of products, never chained through
  // the previous group carry). Returns {carry_out, sum_slice}.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] xa,
                                            input logic [SW-1:0] xb,
                                            input logic          xc);
    logic [GRP_PER_STG-1:0] gg;
    logic [GRP_PER_STG-1:0] gp;
    logic [GRP_PER_STG:0]   gc;
    logic [SW-1:0]          s;
    logic [3:0]             p;
    logic [3:0]             g;
    logic [3:0]             c;
    logic                   term;
    logic                   acc;
    for (int j = 0; j < GRP_PER_STG; j++) begin
      p     = xa[4*j +: 4] | xb[4*j +: 4];
      g     = xa[4*j +: 4] & xb[4*j +: 4];
      gg[j] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
              (p[3] & p[2] & p[1] & g[0]);
      gp[j] = &p;
    end
    gc[0] = xc;
    for (int j = 1; j <= GRP_PER_STG; j++) begin
      // Stage carry-in propagated through all lower groups.
      acc = xc;
      for (int l = 0; l < j; l++) begin
        acc = acc & gp[l];
      end
      // Group m generates, all groups between m and j propagate.
      for (int m = 0; m < j; m++) begin
        term = gg[m];
        for (int l = m + 1; l < j; l++) begin
          term = term & gp[l];
        end
        acc = acc | term;
      end
      gc[j] = acc;
    end
    for (int j = 0; j < GRP_PER_STG; j++) begin
      p    = xa[4*j +: 4] | xb[4*j +: 4];
      g    = xa[4*j +: 4] & xb[4*j +: 4];
      c[0] = gc[j];
      c[1] = g[0] | (p[0] & gc[j]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & gc[j]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
             (p[2] & p[1] & p[0] & gc[j]);
      s[4*j +: 4] = xa[4*j +: 4] ^ xb[4*j +: 4] ^ c;
    end
    return {gc[GRP_PER_STG], s};
  endfunction

  // Pipeline registers. Stage k holds the full (skewed) operands, the sum
  // bits completed so far and the carry out of its own slice.
  logic [NSTG-1:0]            valid_q, valid_d;
  logic [NSTG-1:0]            carry_q, carry_d;
  logic [NSTG-1:0][WIDTH-1:0] a_q, a_d;
  logic [NSTG-1:0][WIDTH-1:0] b_q, b_d;
  logic [NSTG-1:0][WIDTH-1:0] sum_q, sum_d;

  // Inputs seen by each stage: the port side for stage 0, the previous
  // stage's registers otherwise.
  logic [NSTG-1:0]            src_v;
  logic [NSTG-1:0]            src_c;
  logic [NSTG-1:0][WIDTH-1:0] src_a;
  logic [NSTG-1:0][WIDTH-1:0] src_b;
  logic [NSTG-1:0][WIDTH-1:0] src_sum;
  logic [NSTG-1:0][SW:0]      slice_res;
  logic [NSTG-1:0]            stage_ready;

  // Operand preparation at accept; subtraction is a + ~b + 1.
  always_comb begin
    src_v[0]   = in_valid;
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_c[0]   = sub | c_in;
    src_sum[0] = '0;
    for (int k = 1; k < NSTG; k++) begin
      src_v[k]   = valid_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_c[k]   = carry_q[k-1];
      src_sum[k] = sum_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      slice_res[k] = slice_add(src_a[k][k*SW +: SW], src_b[k][k*SW +: SW],
                               src_c[k]);
    end
  end

  // A stage may load when it is empty or when every stage below it up to the
  // output is going to move. Written in closed form (not as a chain over
  // stage_ready itself) so there is no self-referencing combinational vector.
  for (genvar k = 0; k < NSTG; k++) begin : g_ready
    assign stage_ready[k] = out_ready | ~(&valid_q[NSTG-1:k]);
  end

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    for (int k = 0; k < NSTG; k++) begin
      if (stage_ready[k]) begin
        valid_d[k]                = src_v[k];
        a_d[k]                    = src_a[k];
        b_d[k]                    = src_b[k];
        sum_d[k]                  = src_sum[k];
        sum_d[k][k*SW +: SW]      = slice_res[k][SW-1:0];
        carry_d[k]                = slice_res[k][SW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_q[NSTG-1];
  assign sum       = sum_q[NSTG-1];
  assign c_out     = carry_q[NSTG-1];

`ifdef BCLA_OVF_EN
  // Carry into the MSB is recovered as a^b^sum at that bit; overflow is that
  // carry XOR the carry out.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (stage_ready[NSTG-1]) begin
      ovf_d = src_a[NSTG-1][WIDTH-1] ^ src_b[NSTG-1][WIDTH-1] ^
              slice_res[NSTG-1][SW-1] ^ slice_res[NSTG-1][SW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  // Consumed operand bits and not-yet-final sum bits are intentionally left
  // dangling; this collects them in one place.
  logic unused_pipe;
  assign unused_pipe = ^{a_q, b_q, sum_q};

endmodule

// File: tb/tb_bcla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_bcla_addsub_pipe
//
// Self-checking bench for bcla_addsub_pipe (WIDTH=32, GRP_PER_STG=2, NSTG=4).
// Expected results come from an arithmetic reference model (integer add /
// subtract / signed range test) held in an expected queue. Define BCLA_OVF_EN
// for both the DUT and this bench to exercise the ovf output.
// -----------------------------------------------------------------------------
module tb_bcla_addsub_pipe;

  localparam int WIDTH       = 32;
  localparam int GRP_PER_STG = 2;
  localparam int NSTG        = WIDTH / (4 * GRP_PER_STG);
`ifdef BCLA_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             dut_ovf;
  logic [WIDTH+1:0] got;

  always #5 clk = ~clk;

  bcla_addsub_pipe #(
    .WIDTH      (WIDTH),
    .GRP_PER_STG(GRP_PER_STG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out)
`ifdef BCLA_OVF_EN
    ,
    .ovf      (dut_ovf)
`endif
  );

`ifndef BCLA_OVF_EN
  assign dut_ovf = 1'b0;
`endif

  assign got = {dut_ovf, c_out, sum};

  // ---------------- scoreboard state ----------------
  int               n_vec = 0;
  int               n_err = 0;
  logic [WIDTH+1:0] exp_q[$];

  // Reference: {ovf, c_out, sum} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] ra,
                                                 input logic [WIDTH-1:0] rb,
                                                 input logic rsub,
                                                 input logic rcin);
    logic [WIDTH:0] u;
    longint         sres;
    longint         smax;
    longint         smin;
    logic           v;
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -smax - 1;
    if (rsub) begin
      u[WIDTH-1:0] = ra - rb;
      u[WIDTH]     = (ra >= rb);
      sres = longint'($signed(ra)) - longint'($signed(rb));
    end else begin
      u    = {1'b0, ra} + {1'b0, rb} + (WIDTH+1)'(rcin);
      sres = longint'($signed(ra)) + longint'($signed(rb)) + longint'(rcin);
    end
    v = OVF_EN && ((sres > smax) || (sres < smin));
    return {v, u};
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic [WIDTH-1:0] xa,
                          input logic [WIDTH-1:0] xb, input logic xs,
                          input logic xc);
    in_valid = v;
    a        = xa;
    b        = xb;
    sub      = xs;
    c_in     = xc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    set_beat(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_vec++;
    if ({c_out, sum} !== '0) begin
      n_err++; $display("FAIL reset_sum_cout: got %h expected 0", {c_out, sum});
    end
`ifdef BCLA_OVF_EN
    n_vec++;
    if (dut_ovf !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf: got %b expected 0", dut_ovf);
    end
`endif
    next_cycle();
  endtask

  // All-ones + 1: carry must cross every stage; result at exactly NSTG cycles.
  task automatic test_carry_chain();
    out_ready = 1'b1;
    set_beat(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL chain_in_ready: got %b expected 1", in_ready);
    end
    next_cycle();
    for (int c = 1; c <= NSTG; c++) begin
      in_valid = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== (c == NSTG)) begin
        n_err++;
        $display("FAIL chain_latency cycle %0d: got out_valid %b expected %b",
                 c, out_valid, (c == NSTG));
      end
      if (c == NSTG) begin
        n_vec++;
        if ({c_out, sum} !== {1'b1, 32'h0000_0000}) begin
          n_err++;
          $display("FAIL chain_result: got %h expected %h", {c_out, sum},
                   {1'b1, 32'h0000_0000});
        end
      end
      next_cycle();
    end
  endtask

  // Two subtractions with hand-computed results; c_in=1 must be ignored.
  task automatic test_sub();
    exp_q.delete();
    exp_q.push_back({1'b0, 1'b0, 32'hFFFF_FFFE});
    exp_q.push_back({1'b0, 1'b1, 32'h0000_0002});
    out_ready = 1'b1;
    for (int c = 0; c < NSTG + 4; c++) begin
      if (c == 0)      set_beat(1'b1, 32'd5, 32'd7, 1'b1, 1'b1);
      else if (c == 1) set_beat(1'b1, 32'd7, 32'd5, 1'b1, 1'b0);
      else             set_beat(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL sub_extra: got %h expected none", got);
        end else if (got !== exp_q[0]) begin
          n_err++; $display("FAIL sub_result: got %h expected %h", got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      next_cycle();
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sub_missing: got %0d left expected 0", exp_q.size());
    end
  endtask

  // 16 random beats, one per cycle, results one per cycle from cycle NSTG.
  task automatic test_back_to_back();
    logic [WIDTH-1:0] ra, rb;
    logic             rs, rc;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 16 + NSTG + 2; c++) begin
      if (c < 16) begin
        ra = rand_word();
        rb = rand_word();
        if (c % 4 == 1) ra = '1;                 // long carry chains
        rs = (c % 3 == 2);
        rc = (c % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        set_beat(1'b1, ra, rb, rs, rc);
      end else begin
        set_beat(1'b0, '0, '0, 1'b0, 1'b0);
      end
      #1;
      if (c < 16) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL b2b_in_ready cycle %0d: got %b expected 1", c, in_ready);
        end
        exp_q.push_back(ref_model(ra, rb, rs, rc));
      end
      n_vec++;
      if (out_valid !== (c >= NSTG && c < 16 + NSTG)) begin
        n_err++;
        $display("FAIL b2b_out_valid cycle %0d: got %b expected %b", c, out_valid,
                 (c >= NSTG && c < 16 + NSTG));
      end
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: got %h expected none", got);
        end else if (got !== exp_q[0]) begin
          n_err++; $display("FAIL b2b_result cycle %0d: got %h expected %h", c, got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      next_cycle();
    end
  endtask

  // Stall the output: exactly NSTG beats buffered, outputs frozen; then release.
  task automatic test_backpressure();
    logic [WIDTH-1:0] ra, rb;
    logic             rs, rc;
    logic [WIDTH+1:0] snap;
    int               n_new;
    exp_q.delete();
    snap = '0;
    ra = rand_word(); rb = rand_word();
    rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
    out_ready = 1'b0;
    for (int c = 0; c < 2 * NSTG; c++) begin
      set_beat(1'b1, ra, rb, rs, rc);
      #1;
      n_vec++;
      if (in_ready !== (c < NSTG)) begin
        n_err++; $display("FAIL stall_in_ready cycle %0d: got %b expected %b", c, in_ready, (c < NSTG));
      end
      n_vec++;
      if (out_valid !== (c >= NSTG)) begin
        n_err++; $display("FAIL stall_out_valid cycle %0d: got %b expected %b", c, out_valid, (c >= NSTG));
      end
      if (c == NSTG) snap = got;
      if (c > NSTG) begin
        n_vec++;
        if (got !== snap) begin
          n_err++; $display("FAIL stall_stable cycle %0d: got %h expected %h", c, got, snap);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(ra, rb, rs, rc));
        ra = rand_word(); rb = rand_word();
        rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      end
      next_cycle();
    end
    // Release: consume and accept in the same cycles, strict FIFO order.
    out_ready = 1'b1;
    n_new = 0;
    for (int c = 0; c < 6 + NSTG + 4; c++) begin
      set_beat(n_new < 6, ra, rb, rs, rc);
      #1;
      if (c == 0) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
      end
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL release_extra: got %h expected none", got);
        end else if (got !== exp_q[0]) begin
          n_err++; $display("FAIL release_result cycle %0d: got %h expected %h", c, got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(ra, rb, rs, rc));
        n_new++;
        ra = rand_word(); rb = rand_word();
        rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      end
      next_cycle();
    end
    n_vec++;
    if (n_new != 6) begin
      n_err++; $display("FAIL release_resume: got %0d accepted expected 6", n_new);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL release_missing: got %0d left expected 0", exp_q.size());
    end
  endtask

  // Reset with 3 beats in flight: none may emerge; the next beat completes.
  task automatic test_reset_mid();
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH+1:0] exp_v;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_beat(1'b1, rand_word(), rand_word(), 1'b0, 1'b1);
      next_cycle();
    end
    set_beat(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
    end
    for (int c = 0; c < 2 * NSTG; c++) begin
      next_cycle();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL midrst_ghost cycle %0d: got %h expected no output", c, got);
      end
    end
    ra = rand_word();
    rb = rand_word();
    exp_v = ref_model(ra, rb, 1'b1, 1'b0);
    set_beat(1'b1, ra, rb, 1'b1, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    for (int c = 1; c < NSTG; c++) next_cycle();
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL midrst_first_valid: got %b expected 1", out_valid);
    end
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL midrst_first_result: got %h expected %h", got, exp_v);
    end
    next_cycle();
  endtask

`ifdef BCLA_OVF_EN
  task automatic test_ovf();
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, 32'h8000_0000});
    exp_q.push_back({1'b1, 1'b1, 32'h7FFF_FFFF});
    out_ready = 1'b1;
    for (int c = 0; c < NSTG + 4; c++) begin
      if (c == 0)      set_beat(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      else if (c == 1) set_beat(1'b1, 32'h8000_0000, 32'd1, 1'b1, 1'b0);
      else             set_beat(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL ovf_extra: got %h expected none", got);
        end else if (got !== exp_q[0]) begin
          n_err++; $display("FAIL ovf_result: got %h expected %h", got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      next_cycle();
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL ovf_missing: got %0d left expected 0", exp_q.size());
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_carry_chain();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef BCLA_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcla_addsub_pipe.md
Name: bcla_addsub_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit block carry-lookahead adder.
- Computes WIDTH-bit a+b+c_in or a-b using 4-bit lookahead groups.
- A second-level lookahead runs across the groups inside each pipeline stage; the carry is registered between stages.
- Sits in the moddiv datapath as the shared add/subtract engine. Uses a valid/ready handshake with per-stage bubble collapsing.

Parameters:
- WIDTH, 32: operand width. Must be a multiple of 4*GRP_PER_STG.
- GRP_PER_STG, 2: 4-bit lookahead groups per pipeline stage.
- NSTG (localparam), WIDTH/(4*GRP_PER_STG): number of pipeline stages, which equals the latency in cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage 0 can accept a beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = a-b, 0 = a+b+c_in.
- c_in  input  1  carry-in; ignored when sub=1.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB. For sub this means 1 = no borrow.
- ovf  output  1  signed overflow; present only with BCLA_OVF_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. It clears every stage valid bit and every registered carry, sum slice and c_out. Data registers may also clear to 0, and the bench checks them only when qualified by valid. After reset: out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1.
- Operand preparation at accept: b_eff = sub ? ~b : b; cin_eff = sub ? 1 : c_in.
- Per-group lookahead, with i the bit index inside a group:
  - p_i = a_i|b_i, g_i = a_i&b_i.
  - Group G and P computed as in the 4-bit BCLA.
  - sum bits = a^b^carry.
- Per-stage lookahead: carries into each group of stage k come from the group G/P terms and the stage carry-in, via a 2nd-level lookahead with no ripple between groups.
- Stage k slicing:
  - Stage k computes bits [4*GRP_PER_STG*(k+1)-1 : 4*GRP_PER_STG*k].
  - Its carry-in is the carry registered by stage k-1; stage 0 uses cin_eff.
  - Operand bits for later stages are carried forward (skewed) in the pipeline registers.
  - Completed low sum slices are carried forward the same way.
- Handshake:
  - stage_ready[k] = !valid[k] || stage_ready[k+1].
  - stage_ready[NSTG] = out_ready.
  - in_ready = stage_ready[0].
  - A beat is accepted on in_valid && in_ready. A result is consumed on out_valid && out_ready.
- Latency: exactly NSTG cycles from accept to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Backpressure: with out_ready=0 and the pipe full, every stage holds, in_ready=0, and sum/c_out/ovf stay stable.
- Bubble collapsing: empty stages fill while downstream is stalled, so up to NSTG beats are buffered.
- Simultaneous events:
  - Consume at the output and accept at the input in the same cycle both happen; there are no lost or duplicated beats.
  - Ordering is strictly FIFO.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops next cycle. The first beat after rst deasserts completes normally.
- Wrap-around: sum wraps modulo 2^WIDTH and the final carry is reported only on c_out.
- NSTG=1 is legal: one registered stage, latency 1.

Optional Feature:
- Macro: BCLA_OVF_EN.
- Defined: port ovf exists. It is registered alongside c_out and equals carry_into_MSB ^ c_out (two's-complement overflow) for both add and sub.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=32, GRP_PER_STG=2, NSTG=4):
- Reset then a=0xFFFFFFFF, b=0x00000001, sub=0, c_in=0, out_ready=1 -> after 4 cycles out_valid=1, sum=0x00000000, c_out=1; carry crosses all 4 stages.
- a=5, b=7, sub=1 -> sum=0xFFFFFFFE, c_out=0 (borrow). Then a=7, b=5, sub=1 -> sum=0x00000002, c_out=1.
- Back-to-back stream of 16 random beats with out_ready=1 -> 16 results in order, one per cycle, starting at cycle 4. Each result matches the reference model, including the c_in=1 cases.
- Hold out_ready=0 while streaming -> exactly 4 beats accepted, then in_ready=0 and outputs stable. Release out_ready -> 4 results in order, then new beats resume.
- Assert rst for one cycle with 3 beats in flight -> next cycle out_valid=0 and in_ready=1. None of the 3 beats ever appears.
- BCLA_OVF_EN defined: a=0x7FFFFFFF, b=1, sub=0 -> ovf=1, c_out=0. a=0x80000000, b=1, sub=1 -> ovf=1, sum=0x7FFFFFFF.
